// File: rtl/multi_reg_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multi_reg_transfer_sequencer
// Brief    : Sequences LDM/STM/PUSH/POP style multi-register transfers, one
//            register per cycle, with optional base-register writeback.
// Revision : 1.0 - initial release
// ============================================================================
module multi_reg_transfer_sequencer #(
    parameter int REG_LIST_WIDTH = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int WORD_BYTES     = 4,
    parameter int OFFSET_WIDTH   = $clog2(REG_LIST_WIDTH*WORD_BYTES)+2
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic                      is_load_i,
    input  logic                      decrement_i,
    input  logic                      writeback_i,
    input  logic [ADDR_WIDTH-1:0]     base_reg_i,
    input  logic [REG_LIST_WIDTH-1:0] reg_list_i,
    input  logic                      flush_i,
    output logic                      busy_o,
    output logic                      stall_pipeline_o,
    output logic                      xfer_valid_o,
    output logic [ADDR_WIDTH-1:0]     xfer_reg_addr_o,
    output logic [OFFSET_WIDTH-1:0]   xfer_offset_o,
    output logic                      mem_write_en_o,
    output logic                      mem_read_en_o,
    output logic                      reg_write_en_o,
    output logic                      wb_valid_o,
    output logic [ADDR_WIDTH-1:0]     wb_reg_addr_o,
    output logic [OFFSET_WIDTH-1:0]   wb_offset_o,
    output logic                      done_o
);

    localparam int CNT_W = $clog2(REG_LIST_WIDTH+1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [REG_LIST_WIDTH-1:0] r_list;
    logic                      r_is_load;
    logic                      r_dec;
    logic                      r_wb;
    logic [ADDR_WIDTH-1:0]     r_base;
    logic [CNT_W-1:0]          r_n;
    logic [CNT_W-1:0]          r_k;

    logic [CNT_W-1:0]          w_pop;
    logic                      w_base_hit;
    logic                      w_wb_eff;
    logic [REG_LIST_WIDTH-1:0] w_low;
    logic [ADDR_WIDTH-1:0]     w_idx;
    logic                      w_last;
    logic [OFFSET_WIDTH-1:0]   w_fwd_mag;
    logic [OFFSET_WIDTH-1:0]   w_back_mag;
    logic [OFFSET_WIDTH-1:0]   w_tot_mag;
    logic                      w_valid;
    logic                      w_wb_valid;
    logic                      w_done;
    logic                      w_stall;

    always_comb begin
        w_pop      = '0;
        w_base_hit = 1'b0;
        for (int i = 0; i < REG_LIST_WIDTH; i++) begin
            w_pop = w_pop + CNT_W'(reg_list_i[i]);
            if (base_reg_i == ADDR_WIDTH'(i))
                w_base_hit = w_base_hit | reg_list_i[i];
        end
    end

    // A load that overwrites the base register keeps the loaded value.
    assign w_wb_eff = writeback_i & ~(is_load_i & w_base_hit);

    // Isolate the lowest remaining set bit and encode its index.
    assign w_low = r_list & (~r_list + 1'b1);
    always_comb begin
        w_idx = '0;
        for (int i = REG_LIST_WIDTH-1; i >= 0; i--) begin
            if (r_list[i])
                w_idx = ADDR_WIDTH'(i);
        end
    end

    assign w_last     = (CNT_W'(r_k + 1'b1) == r_n);
    assign w_fwd_mag  = OFFSET_WIDTH'(r_k) * OFFSET_WIDTH'(WORD_BYTES);
    assign w_back_mag = OFFSET_WIDTH'(r_n - r_k) * OFFSET_WIDTH'(WORD_BYTES);
    assign w_tot_mag  = OFFSET_WIDTH'(r_n) * OFFSET_WIDTH'(WORD_BYTES);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= S_IDLE;
            r_list    <= '0;
            r_is_load <= 1'b0;
            r_dec     <= 1'b0;
            r_wb      <= 1'b0;
            r_base    <= '0;
            r_n       <= '0;
            r_k       <= '0;
        end else begin
            r_state <= w_next;
            if (flush_i) begin
                r_list    <= '0;
                r_is_load <= 1'b0;
                r_dec     <= 1'b0;
                r_wb      <= 1'b0;
                r_base    <= '0;
                r_n       <= '0;
                r_k       <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_list    <= reg_list_i;
                            r_is_load <= is_load_i;
                            r_dec     <= decrement_i;
                            r_wb      <= w_wb_eff;
                            r_base    <= base_reg_i;
                            r_n       <= w_pop;
                            r_k       <= '0;
                        end
                    end
                    S_XFER: begin
                        r_list <= r_list & ~w_low;
                        r_k    <= r_k + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_valid    = 1'b0;
        w_wb_valid = 1'b0;
        w_done     = 1'b0;
        w_stall    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (w_pop != '0) begin
                        w_next  = S_XFER;
                        w_stall = 1'b1;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            S_XFER: begin
                w_valid = 1'b1;
                if (w_last) begin
                    w_next  = r_wb ? S_WB : S_IDLE;
                    w_done  = ~r_wb;
                    w_stall = r_wb;
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_WB: begin
                w_wb_valid = 1'b1;
                w_done     = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Abort overrides everything, including a start in IDLE.
        if (flush_i) begin
            w_next     = S_IDLE;
            w_valid    = 1'b0;
            w_wb_valid = 1'b0;
            w_done     = 1'b0;
            w_stall    = 1'b0;
        end
    end

    assign busy_o           = (r_state != S_IDLE);
    assign stall_pipeline_o = w_stall;
    assign xfer_valid_o     = w_valid;
    assign xfer_reg_addr_o  = (r_state == S_XFER) ? w_idx : '0;
    assign xfer_offset_o    = (r_state != S_XFER) ? '0 :
                              (r_dec ? (~w_back_mag + 1'b1) : w_fwd_mag);
    assign mem_write_en_o   = w_valid & ~r_is_load;
    assign mem_read_en_o    = w_valid & r_is_load;
    assign reg_write_en_o   = (w_valid & r_is_load) | w_wb_valid;
    assign wb_valid_o       = w_wb_valid;
    assign wb_reg_addr_o    = r_base;
    assign wb_offset_o      = (r_state != S_WB) ? '0 :
                              (r_dec ? (~w_tot_mag + 1'b1) : w_tot_mag);
    assign done_o           = w_done;

endmodule
`default_nettype wire

// File: tb/tb_multi_reg_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_reg_transfer_sequencer
// Brief    : Scoreboard bench for the multi-register transfer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_reg_transfer_sequencer;

    localparam int RLW = 8;
    localparam int AW  = 4;
    localparam int WB  = 4;
    localparam int OW  = $clog2(RLW*WB)+2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0, is_load = 1'b0, decr = 1'b0, wback = 1'b0, flush = 1'b0;
    logic [AW-1:0] base = '0;
    logic [RLW-1:0] list = '0;
    logic          busy, stall, xv, mwe, mre, rwe, wbv, done;
    logic [AW-1:0] xaddr, wbaddr;
    logic [OW-1:0] xoff, wboff;

    multi_reg_transfer_sequencer #(
        .REG_LIST_WIDTH(RLW), .ADDR_WIDTH(AW), .WORD_BYTES(WB), .OFFSET_WIDTH(OW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .is_load_i(is_load),
        .decrement_i(decr), .writeback_i(wback), .base_reg_i(base), .reg_list_i(list),
        .flush_i(flush), .busy_o(busy), .stall_pipeline_o(stall), .xfer_valid_o(xv),
        .xfer_reg_addr_o(xaddr), .xfer_offset_o(xoff), .mem_write_en_o(mwe),
        .mem_read_en_o(mre), .reg_write_en_o(rwe), .wb_valid_o(wbv),
        .wb_reg_addr_o(wbaddr), .wb_offset_o(wboff), .done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_wb;
        bit load;
        int addr;
        int off;
        bit done;
        bit stall;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference sequence: returns the busy-cycle count it expects.
    task automatic push_seq(input logic [RLW-1:0] l, input bit ld, input bit dc,
                            input bit wbk, input int b, output int cycles);
        int   n, k;
        bit   wbe;
        exp_t e;
        n = $countones(l);
        wbe = wbk && !(ld && b < RLW && l[b]);
        k = 0;
        for (int i = 0; i < RLW; i++) begin
            if (l[i]) begin
                e.is_wb = 0; e.load = ld; e.addr = i;
                e.off   = dc ? (k - n) * WB : k * WB;
                e.done  = (k == n-1) && !wbe;
                e.stall = !e.done;
                q.push_back(e);
                k++;
            end
        end
        if (wbe && n > 0) begin
            e.is_wb = 1; e.load = ld; e.addr = b;
            e.off   = dc ? -n * WB : n * WB;
            e.done  = 1; e.stall = 0;
            q.push_back(e);
        end
        cycles = (n == 0) ? 0 : n + (wbe ? 1 : 0);
    endtask

    task automatic cmp_out();
        exp_t e;
        if (q.size() == 0) begin
            chk("unexpected_busy_cycle", 1, 0);
            return;
        end
        e = q.pop_front();
        chk("busy", int'(busy), 1);
        chk("done", int'(done), int'(e.done));
        chk("stall", int'(stall), int'(e.stall));
        if (!e.is_wb) begin
            chk("xfer_valid", int'(xv), 1);
            chk("wb_valid", int'(wbv), 0);
            chk("xfer_addr", int'(xaddr), e.addr);
            chk("xfer_off", int'($signed(xoff)), e.off);
            chk("mem_we", int'(mwe), int'(!e.load));
            chk("mem_re", int'(mre), int'(e.load));
            chk("reg_we", int'(rwe), int'(e.load));
        end else begin
            chk("wb_valid", int'(wbv), 1);
            chk("xfer_valid", int'(xv), 0);
            chk("wb_addr", int'(wbaddr), e.addr);
            chk("wb_off", int'($signed(wboff)), e.off);
            chk("wb_reg_we", int'(rwe), 1);
            chk("wb_mem_en", int'(mwe | mre), 0);
        end
    endtask

    task automatic run_seq(input logic [RLW-1:0] l, input bit ld, input bit dc,
                           input bit wbk, input int b);
        int exp_cyc, got_cyc;
        push_seq(l, ld, dc, wbk, b, exp_cyc);
        tick();
        start = 1; list = l; is_load = ld; decr = dc; wback = wbk; base = AW'(b);
        #1;
        chk("acc_busy", int'(busy), 0);
        chk("acc_stall", int'(stall), int'(exp_cyc > 0));
        chk("acc_done", int'(done), int'(exp_cyc == 0));
        chk("acc_xv", int'(xv), 0);
        got_cyc = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            start = 0;
            #1;
            if (!busy) break;
            got_cyc++;
            cmp_out();
        end
        chk("busy_cycles", got_cyc, exp_cyc);
        chk("queue_drained", q.size(), 0);
        q.delete();
    endtask

    function automatic int all_outs();
        return int'(busy) + int'(stall) + int'(xv) + int'(xaddr) + int'(xoff) + int'(mwe)
             + int'(mre) + int'(rwe) + int'(wbv) + int'(wbaddr) + int'(wboff) + int'(done);
    endfunction

    initial begin
        int dummy;
        #12;
        chk("reset_outputs", all_outs(), 0);
        reset_n = 1;

        // STM increment, no writeback
        run_seq(8'b1000_0101, 0, 0, 0, 13);
        // PUSH style: store, decrement, writeback
        run_seq(8'b0011_0000, 0, 1, 1, 13);
        // LDM with base in list: writeback suppressed
        run_seq(8'b0000_0110, 1, 0, 1, 2);
        // POP style: load, increment, writeback, base not in list
        run_seq(8'b1100_0001, 1, 0, 1, 13);
        // Full list with decrement and writeback: worst-case offsets
        run_seq(8'hFF, 0, 1, 1, 13);
        // Empty list
        run_seq(8'h00, 0, 0, 1, 13);

        // Flush on the 2nd transfer of a full list
        push_seq(8'hFF, 0, 0, 0, 13, dummy);
        tick();
        start = 1; list = 8'hFF; is_load = 0; decr = 0; wback = 0; base = 4'd13;
        tick();
        start = 0;
        #1;
        cmp_out();
        tick();
        flush = 1;
        #1;
        chk("flush_xv", int'(xv), 0);
        chk("flush_en", int'(mwe | mre | rwe | wbv), 0);
        chk("flush_done", int'(done), 0);
        chk("flush_stall", int'(stall), 0);
        tick();
        flush = 0;
        #1;
        chk("post_flush_busy", int'(busy), 0);
        chk("post_flush_done", int'(done), 0);
        q.delete();
        // flush together with start in IDLE drops the start
        start = 1; flush = 1; list = 8'h0F;
        #1;
        chk("flush_start_stall", int'(stall), 0);
        tick();
        start = 0; flush = 0;
        #1;
        chk("flush_start_busy", int'(busy), 0);
        run_seq(8'b0000_1001, 1, 1, 1, 13);

        // Start while busy is ignored, then reset mid-sequence
        push_seq(8'b1111_0000, 0, 0, 1, 13, dummy);
        tick();
        start = 1; list = 8'b1111_0000; is_load = 0; decr = 0; wback = 1; base = 4'd13;
        tick();
        start = 0;
        #1;
        cmp_out();
        tick();
        start = 1; list = 8'h01; is_load = 1; decr = 1; wback = 0; base = 4'd0;
        #1;
        cmp_out();
        tick();
        start = 0;
        #1;
        cmp_out();
        #2;
        reset_n = 0;
        #1;
        chk("midseq_reset_outputs", all_outs(), 0);
        @(negedge clk);
        reset_n = 1;
        q.delete();
        tick();
        #1;
        chk("after_reset_busy", int'(busy), 0);
        run_seq(8'b0101_0000, 0, 0, 0, 13);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/multi_reg_transfer_sequencer.md
Name: multi_reg_transfer_sequencer

Overview:
- Parametrised sequencer for multi-register load/store instructions (LDM/STM/PUSH/POP class). It sits beside the cpu controller in decode.
- Accepts a register list and mode bits, then emits one register transfer per cycle, visiting only the set list bits. It produces register address, byte offset and memory/regfile enables, plus optional base writeback.
- Drives the pipeline stall until the sequence's last cycle.
- New over the current scheme: skips unset bits, supports the decrement-before mode, supports base writeback, supports abort, and is parametrised in list width.

Parameters:
- REG_LIST_WIDTH, 8, number of register-list bits; bit i selects register i.
- ADDR_WIDTH, 4, register file address width; must satisfy 2**ADDR_WIDTH >= REG_LIST_WIDTH.
- WORD_BYTES, 4, bytes per transferred register.
- OFFSET_WIDTH, $clog2(REG_LIST_WIDTH*WORD_BYTES)+2, width of the signed two's-complement offsets.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  request a new sequence; honoured only in IDLE.
- is_load_i  input  1  1 = load (mem->reg), 0 = store (reg->mem).
- decrement_i  input  1  1 = decrement-before (push style), 0 = increment-after.
- writeback_i  input  1  update the base register after the transfers.
- base_reg_i  input  ADDR_WIDTH  base register address.
- reg_list_i  input  REG_LIST_WIDTH  register list.
- flush_i  input  1  abort the current sequence.
- busy_o  output  1  sequencer not in IDLE.
- stall_pipeline_o  output  1  hold upstream pipeline stages.
- xfer_valid_o  output  1  transfer issued this cycle.
- xfer_reg_addr_o  output  ADDR_WIDTH  register being transferred.
- xfer_offset_o  output  OFFSET_WIDTH  signed byte offset from the base.
- mem_write_en_o  output  1  xfer_valid_o & store.
- mem_read_en_o  output  1  xfer_valid_o & load.
- reg_write_en_o  output  1  load transfer or writeback cycle.
- wb_valid_o  output  1  base writeback this cycle.
- wb_reg_addr_o  output  ADDR_WIDTH  equal to the latched base register.
- wb_offset_o  output  OFFSET_WIDTH  +N*WORD_BYTES or -N*WORD_BYTES.
- done_o  output  1  one-cycle pulse on the final cycle of a sequence.

Behaviour:
- Reset (async, reset_n_i=0):
  - State = IDLE.
  - Latched list, mode, base and counters cleared.
  - Every output is 0.
- States: IDLE, XFER, WB.
- IDLE:
  - On start_i, latch reg_list_i, is_load_i, decrement_i, writeback_i and base_reg_i; set N = popcount(list) and k = 0.
  - If N > 0, go to XFER.
  - If N = 0, pulse done_o in this same cycle. No transfer, no writeback, no stall; stay in IDLE.
  - stall_pipeline_o = start_i & (N > 0) in the accept cycle. The cycle is combinational from the inputs.
- XFER (one transfer per cycle, lowest set bit first):
  - xfer_reg_addr_o = index of the lowest remaining set bit; that bit is cleared on the clock edge; k increments.
  - xfer_offset_o = k*WORD_BYTES when increment-after, (k-N)*WORD_BYTES when decrement-before.
  - After the last set bit: go to WB if writeback is active, else go to IDLE.
- Writeback suppression: a load whose list contains base_reg_i has writeback suppressed; the loaded value wins.
- WB (single cycle):
  - wb_valid_o = 1, reg_write_en_o = 1.
  - wb_offset_o = +N*WORD_BYTES for increment, -N*WORD_BYTES for decrement.
  - Next state IDLE.
- Final cycle of a sequence (last XFER when no WB, or the WB cycle): done_o = 1 and stall_pipeline_o = 0. Every earlier busy cycle has stall_pipeline_o = 1.
- Latency: the first transfer occurs one cycle after start is accepted. Total busy cycles = N + (writeback effective ? 1 : 0).
- start_i while busy is ignored; the latched state is unchanged.
- flush_i:
  - Highest priority, checked in any state.
  - Combinationally zeroes xfer_valid_o, all enables, wb_valid_o, done_o and stall_pipeline_o in that cycle.
  - Next state IDLE with the latched state cleared.
  - flush_i with start_i in IDLE: start is dropped.
- Reset mid-sequence: immediate return to IDLE with all outputs 0; no done_o.
- Full list (all REG_LIST_WIDTH bits set): N = REG_LIST_WIDTH. Offsets must not overflow OFFSET_WIDTH; worst case is ±REG_LIST_WIDTH*WORD_BYTES.
- Popcount and offsets are computed unsigned, then sign-applied; no truncation is permitted.

Test Plan:
- STM increment, list=8'b1000_0101, base=r13, no writeback:
  - Transfers are r0@0, r2@4, r7@8 on cycles 1-3.
  - mem_write_en_o high on those cycles.
  - stall high on cycles 0-2, low on cycle 3; done_o on cycle 3.
- PUSH style, store, decrement, writeback, list=8'b0011_0000, base=r13:
  - Transfers are r4@-8, r5@-4.
  - WB cycle has wb_offset_o=-8 and done_o; 3 busy cycles.
- LDM increment, writeback, list includes base (list=8'b0000_0110, base=r2):
  - Loads r1@0, r2@4 with reg_write_en_o high.
  - No WB cycle; done_o on the r2 cycle.
- Empty list with start_i:
  - done_o in the same cycle.
  - busy_o, stall and xfer_valid_o stay 0.
- flush_i asserted on the 2nd XFER of a full list 8'hFF:
  - That cycle shows no enables.
  - Next cycle is IDLE with busy_o=0 and no done_o.
  - A new start_i is then accepted normally.
- reset_n_i low mid-sequence, plus start_i while busy:
  - Outputs are 0 immediately on reset.
  - A start while busy leaves the in-flight sequence's addresses and offsets unchanged.
